// File: rtl/latch_if_id_if.sv
// IF/ID pipeline register bus: fetch-side inputs, stall/flush controls and the registered ID-side outputs.
interface latch_if_id_if;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instruction;
    logic        id_valid;
    logic [1:0]  state;

    modport master (
        output stall, flush, if_pc, if_instruction, if_valid,
        input  id_pc, id_instruction, id_valid, state
    );

    modport slave (
        input  stall, flush, if_pc, if_instruction, if_valid,
        output id_pc, id_instruction, id_valid, state
    );
endinterface

// File: rtl/latch_if_id.sv
// IF/ID pipeline register with stall (hold/bubble) and flush handling.
// Optional saturating stall-analysis counters enabled by LATCH_IF_ID_PERF_EN.
module latch_if_id #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input logic          clock,
    input logic          reset,
    latch_if_id_if.slave bus
`ifdef LATCH_IF_ID_PERF_EN
    ,
    output logic [31:0]  perf_bubble_count,
    output logic [31:0]  perf_hold_count,
    output logic [31:0]  perf_flush_count
`endif
);
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ACT_CAPTURE = 2'd0,
        ACT_HOLD    = 2'd1,
        ACT_BUBBLE  = 2'd2,
        ACT_FLUSH   = 2'd3
    } action_e;

    action_e           action_c;
    action_e           state_q;
    logic [DATA_W-1:0] id_pc_q;
    logic [DATA_W-1:0] id_instruction_q;
    logic              id_valid_q;
    logic [DATA_W-1:0] pc_d;
    logic [DATA_W-1:0] instruction_d;
    logic              valid_d;

    // Only stall[1] (IF) and stall[2] (ID) matter to this stage.
    logic unused_stall;
    assign unused_stall = ^{bus.stall[5:3], bus.stall[0]};

    // Action selection in strict priority; reset reuses the flush load.
    always_comb begin
        action_c = ACT_CAPTURE;
        if (reset || bus.flush) begin
            action_c = ACT_FLUSH;
        end else if (bus.stall[1] && !bus.stall[2]) begin
            action_c = ACT_BUBBLE;
        end else if (bus.stall[1]) begin
            action_c = ACT_HOLD;
        end
    end

    // Next data register values for the selected action.
    always_comb begin
        pc_d          = id_pc_q;
        instruction_d = id_instruction_q;
        valid_d       = id_valid_q;
        case (action_c)
            ACT_CAPTURE: begin
                pc_d          = bus.if_pc;
                instruction_d = bus.if_valid ? bus.if_instruction : NOP_WORD;
                valid_d       = bus.if_valid;
            end
            ACT_HOLD: begin
                pc_d          = id_pc_q;
                instruction_d = id_instruction_q;
                valid_d       = id_valid_q;
            end
            default: begin
                pc_d          = '0;
                instruction_d = NOP_WORD;
                valid_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        state_q          <= action_c;
        id_pc_q          <= pc_d;
        id_instruction_q <= instruction_d;
        id_valid_q       <= valid_d;
    end

    assign bus.id_pc          = id_pc_q;
    assign bus.id_instruction = id_instruction_q;
    assign bus.id_valid       = id_valid_q;
    assign bus.state          = state_q;

`ifdef LATCH_IF_ID_PERF_EN
    localparam logic [DATA_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] perf_bubble_q;
    logic [DATA_W-1:0] perf_hold_q;
    logic [DATA_W-1:0] perf_flush_q;

    // Saturating counters; only reset clears them, flush just counts.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_bubble_q <= '0;
            perf_hold_q   <= '0;
            perf_flush_q  <= '0;
        end else begin
            if (action_c == ACT_BUBBLE && perf_bubble_q != CNT_MAX) begin
                perf_bubble_q <= perf_bubble_q + DATA_W'(1);
            end
            if (action_c == ACT_HOLD && perf_hold_q != CNT_MAX) begin
                perf_hold_q <= perf_hold_q + DATA_W'(1);
            end
            if (action_c == ACT_FLUSH && perf_flush_q != CNT_MAX) begin
                perf_flush_q <= perf_flush_q + DATA_W'(1);
            end
        end
    end

    assign perf_bubble_count = perf_bubble_q;
    assign perf_hold_count   = perf_hold_q;
    assign perf_flush_count  = perf_flush_q;
`endif
endmodule

// File: tb/tb_latch_if_id.sv
// Scoreboard bench for latch_if_id: expected ID-side words queued at drive time, compared after each edge.
module tb_latch_if_id;
    localparam logic [31:0] TB_NOP = 32'h0000_0020;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic [1:0]  st;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    latch_if_id_if bus ();

`ifdef LATCH_IF_ID_PERF_EN
    logic [31:0] bubble_cnt;
    logic [31:0] hold_cnt;
    logic [31:0] flush_cnt;
`endif

    latch_if_id #(.NOP_WORD(TB_NOP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef LATCH_IF_ID_PERF_EN
        ,
        .perf_bubble_count (bubble_cnt),
        .perf_hold_count   (hold_cnt),
        .perf_flush_count  (flush_cnt)
`endif
    );

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                input logic valid, input logic [1:0] st);
        exp_t e;
        e.pc = pc; e.instr = instr; e.valid = valid; e.st = st;
        return e;
    endfunction

    function automatic exp_t observed();
        return {bus.id_pc, bus.id_instruction, bus.id_valid, bus.state};
    endfunction

    // Drive one cycle of stimulus, queue its expectation, then settle past the edge.
    task automatic apply(input logic rst, input logic [5:0] stl, input logic fl,
                         input logic [31:0] pc, input logic [31:0] instr,
                         input logic vld, input exp_t e);
        reset              = rst;
        bus.stall          = stl;
        bus.flush          = fl;
        bus.if_pc          = pc;
        bus.if_instruction = instr;
        bus.if_valid       = vld;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, o;
        apply(1'b1, 6'b000000, 1'b0, 32'h0000_0100, 32'h1234_5678, 1'b1, mk(32'h0, TB_NOP, 1'b0, 2'd3));
        e = sb.pop_front(); o = observed(); checks++;
        if (o !== e) begin failures++; $display("FAIL reset: got %h want %h", o, e); end
`ifdef LATCH_IF_ID_PERF_EN
        checks++;
        if ({bubble_cnt, hold_cnt, flush_cnt} !== 96'h0) begin
            failures++; $display("FAIL reset_counters: got %h %h %h want 0", bubble_cnt, hold_cnt, flush_cnt);
        end
`endif
    endtask

    task automatic test_capture();
        exp_t e, o;
        apply(1'b0, 6'b000000, 1'b0, 32'h0000_0004, 32'h3401_1100, 1'b1, mk(32'h4, 32'h3401_1100, 1'b1, 2'd0));
        e = sb.pop_front(); o = observed(); checks++;
        if (o !== e) begin failures++; $display("FAIL capture: got %h want %h", o, e); end
    endtask

    task automatic test_hold();
        exp_t e, o;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 6'b000111, 1'b0, 32'h0000_0008, 32'h2002_0008 + 32'(i), 1'b1,
                  mk(32'h4, 32'h3401_1100, 1'b1, 2'd1));
            e = sb.pop_front(); o = observed(); checks++;
            if (o !== e) begin failures++; $display("FAIL hold[%0d]: got %h want %h", i, o, e); end
        end
`ifdef LATCH_IF_ID_PERF_EN
        checks++;
        if (hold_cnt !== 32'd3) begin failures++; $display("FAIL hold_count: got %0d want 3", hold_cnt); end
`endif
    endtask

    task automatic test_bubble();
        exp_t e, o;
        apply(1'b0, 6'b000011, 1'b0, 32'h0000_0008, 32'h2002_0008, 1'b1, mk(32'h0, TB_NOP, 1'b0, 2'd2));
        e = sb.pop_front(); o = observed(); checks++;
        if (o !== e) begin failures++; $display("FAIL bubble: got %h want %h", o, e); end
`ifdef LATCH_IF_ID_PERF_EN
        checks++;
        if (bubble_cnt !== 32'd1) begin failures++; $display("FAIL bubble_count: got %0d want 1", bubble_cnt); end
`endif
        apply(1'b0, 6'b000000, 1'b0, 32'h0000_000C, 32'h2003_000C, 1'b1, mk(32'hC, 32'h2003_000C, 1'b1, 2'd0));
        e = sb.pop_front(); o = observed(); checks++;
        if (o !== e) begin failures++; $display("FAIL bubble_release: got %h want %h", o, e); end
    endtask

    task automatic test_flush();
        exp_t e, o;
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 6'b000111, 1'b1, 32'h0000_0010, 32'h2004_0010, 1'b1, mk(32'h0, TB_NOP, 1'b0, 2'd3));
            e = sb.pop_front(); o = observed(); checks++;
            if (o !== e) begin failures++; $display("FAIL flush[%0d]: got %h want %h", i, o, e); end
`ifdef LATCH_IF_ID_PERF_EN
            checks++;
            if (flush_cnt !== 32'(i + 1) || hold_cnt !== 32'd3) begin
                failures++; $display("FAIL flush_count[%0d]: got flush=%0d hold=%0d want flush=%0d hold=3",
                                     i, flush_cnt, hold_cnt, i + 1);
            end
`endif
        end
    endtask

    task automatic test_fetch_not_ready();
        exp_t e, o;
        apply(1'b0, 6'b000000, 1'b0, 32'h0000_0014, 32'hFFFF_FFFF, 1'b0, mk(32'h14, TB_NOP, 1'b0, 2'd0));
        e = sb.pop_front(); o = observed(); checks++;
        if (o !== e) begin failures++; $display("FAIL fetch_not_ready: got %h want %h", o, e); end
    endtask

    task automatic test_stall_decode();
        exp_t e, o;
        // stall[1]=0 with stall[2]=1 still captures; unused bits never change the action.
        apply(1'b0, 6'b000100, 1'b0, 32'h0000_0018, 32'h2005_0018, 1'b1, mk(32'h18, 32'h2005_0018, 1'b1, 2'd0));
        e = sb.pop_front(); o = observed(); checks++;
        if (o !== e) begin failures++; $display("FAIL illegal_stall: got %h want %h", o, e); end
        apply(1'b0, 6'b111001, 1'b0, 32'h0000_001C, 32'h2006_001C, 1'b1, mk(32'h1C, 32'h2006_001C, 1'b1, 2'd0));
        e = sb.pop_front(); o = observed(); checks++;
        if (o !== e) begin failures++; $display("FAIL ignored_bits_capture: got %h want %h", o, e); end
        apply(1'b0, 6'b111011, 1'b0, 32'h0000_0020, 32'h2007_0020, 1'b1, mk(32'h0, TB_NOP, 1'b0, 2'd2));
        e = sb.pop_front(); o = observed(); checks++;
        if (o !== e) begin failures++; $display("FAIL ignored_bits_bubble: got %h want %h", o, e); end
`ifdef LATCH_IF_ID_PERF_EN
        checks++;
        if (bubble_cnt !== 32'd2) begin failures++; $display("FAIL bubble_count2: got %0d want 2", bubble_cnt); end
`endif
    endtask

    task automatic test_reset_mid_stall();
        exp_t e, o;
        apply(1'b1, 6'b000111, 1'b1, 32'h0000_0024, 32'h2008_0024, 1'b1, mk(32'h0, TB_NOP, 1'b0, 2'd3));
        e = sb.pop_front(); o = observed(); checks++;
        if (o !== e) begin failures++; $display("FAIL reset_mid_stall: got %h want %h", o, e); end
`ifdef LATCH_IF_ID_PERF_EN
        checks++;
        if ({bubble_cnt, hold_cnt, flush_cnt} !== 96'h0) begin
            failures++; $display("FAIL reset_mid_stall_counters: got %h %h %h want 0", bubble_cnt, hold_cnt, flush_cnt);
        end
`endif
        apply(1'b0, 6'b000111, 1'b0, 32'h0000_0028, 32'h2009_0028, 1'b1, mk(32'h0, TB_NOP, 1'b0, 2'd1));
        e = sb.pop_front(); o = observed(); checks++;
        if (o !== e) begin failures++; $display("FAIL hold_after_reset: got %h want %h", o, e); end
        apply(1'b0, 6'b000000, 1'b0, 32'h0000_002C, 32'h200A_002C, 1'b1, mk(32'h2C, 32'h200A_002C, 1'b1, 2'd0));
        e = sb.pop_front(); o = observed(); checks++;
        if (o !== e) begin failures++; $display("FAIL capture_after_hold: got %h want %h", o, e); end
    endtask

`ifdef LATCH_IF_ID_PERF_EN
    task automatic test_saturation();
        exp_t e, o;
        force dut.perf_hold_q = 32'hFFFF_FFFE;
        #1;
        release dut.perf_hold_q;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 6'b000111, 1'b0, 32'h0000_0030, 32'h200B_0030, 1'b1, mk(32'h2C, 32'h200A_002C, 1'b1, 2'd1));
            e = sb.pop_front(); o = observed(); checks++;
            if (o !== e) begin failures++; $display("FAIL sat_hold[%0d]: got %h want %h", i, o, e); end
            checks++;
            if (hold_cnt !== 32'hFFFF_FFFF) begin
                failures++; $display("FAIL saturation[%0d]: got %h want ffffffff", i, hold_cnt);
            end
        end
        apply(1'b1, 6'b000000, 1'b0, 32'h0000_0034, 32'h200C_0034, 1'b1, mk(32'h0, TB_NOP, 1'b0, 2'd3));
        e = sb.pop_front(); o = observed(); checks++;
        if (o !== e) begin failures++; $display("FAIL sat_reset: got %h want %h", o, e); end
        checks++;
        if (hold_cnt !== 32'h0) begin failures++; $display("FAIL sat_reset_count: got %h want 0", hold_cnt); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset              = 1'b1;
        bus.stall          = '0;
        bus.flush          = 1'b0;
        bus.if_pc          = '0;
        bus.if_instruction = '0;
        bus.if_valid       = 1'b0;
        @(negedge clock);
        test_reset();
        test_capture();
        test_hold();
        test_bubble();
        test_flush();
        test_fetch_not_ready();
        test_stall_decode();
        test_reset_mid_stall();
`ifdef LATCH_IF_ID_PERF_EN
        test_saturation();
`endif
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drain: got %0d want 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/latch_if_id.md
# latch_if_id

Pipeline register between the fetch stage and the decode stage of the 5-stage MIPS core. Captures the fetched PC/instruction pair each cycle and presents it to ID. Applies the shared 6-bit stall vector (hold vs. bubble insertion) and the pipeline flush. Optionally keeps saturating performance counters for stall analysis.

## Interface
Parameters:
- `NOP_WORD`, default `32'h0000_0000`: instruction word presented during bubbles (`sll $0,$0,0`).

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  6  pipeline stall vector; bit 1 = IF held, bit 2 = ID held.
- `flush`  in  1  squash the IF/ID contents; exception/eret path.
- `if_pc`  in  32  PC of the word being fetched.
- `if_instruction`  in  32  instruction ROM read data for `if_pc`.
- `if_valid`  in  1  fetch-side chip enable; 0 while IF is coming out of reset.
- `id_pc`  out  32  registered PC to ID.
- `id_instruction`  out  32  registered instruction to ID.
- `id_valid`  out  1  1 = `id_instruction` is a real fetched word.
- `state`  out  2  action taken on the last edge: 0 CAPTURE, 1 HOLD, 2 BUBBLE, 3 FLUSH.
- `perf_bubble_count`  out  32  present only with `LATCH_IF_ID_PERF_EN`.
- `perf_hold_count`  out  32  present only with `LATCH_IF_ID_PERF_EN`.
- `perf_flush_count`  out  32  present only with `LATCH_IF_ID_PERF_EN`.

## Operation
- Each rising edge evaluates, in strict priority:
  1. `reset`: `id_pc`=0, `id_instruction`=`NOP_WORD`, `id_valid`=0, `state`=3, counters=0.
  2. `flush`: same register values as reset; `state`=3; flush counter +1. Overrides any stall.
  3. `stall[1]`=1, `stall[2]`=0, i.e. IF stalled while ID advances: insert bubble. Registers as reset; `state`=2; bubble counter +1.
  4. `stall[1]`=1, `stall[2]`=1: hold. All data registers keep their value; `state`=1; hold counter +1.
  5. `stall[1]`=0: capture. `id_pc`<=`if_pc`; `id_valid`<=`if_valid`; `id_instruction`<=`if_instruction` when `if_valid`=1, else `NOP_WORD`; `state`=0.
- `stall[1]`=0 with `stall[2]`=1 is illegal from the stall controller. The block treats it as capture (case 5), since `stall[1]` alone decides.
- `stall[0]`, `stall[3..5]` are ignored.
- When `if_valid`=0, `if_pc` is don't-care but is still captured verbatim.
- No combinational path from any input to any output.

## Timing
- Latency 1 cycle: the word on `if_*` at edge N is on `id_*` after edge N.
- Hold preserves outputs for any number of cycles. On the first cycle with `stall[1]`=0, the current `if_*` is captured; no replay of older words.
- Reset mid-stall or mid-flush: reset wins that edge; the next edge follows the normal priority.
- Back-to-back flush: each edge with `flush`=1 reloads the bubble and increments the flush counter.
- All outputs are valid from the first edge after `reset` asserts.

## Configuration
- `LATCH_IF_ID_PERF_EN` defined:
  - the three 32-bit counter ports exist;
  - each increments by 1 on every edge whose action matches (BUBBLE/HOLD/FLUSH);
  - each saturates at `32'hFFFF_FFFF` and does not wrap;
  - reset clears them; flush does not clear them.
- Undefined: the counter ports and their logic are absent; all other behaviour is identical.

## Test plan
- Reset then capture: reset 1 cycle, then `if_pc`=`32'h0000_0004`, `if_instruction`=`32'h3401_1100`, `if_valid`=1, stall=0. Next edge: `id_pc`=4, `id_instruction`=`32'h3401_1100`, `id_valid`=1, `state`=0.
- Hold: after the capture above, stall=`6'b000111` for 3 cycles while `if_*` changes to pc 8. Outputs stay at pc 4 / `32'h3401_1100`; `state`=1; hold counter=3.
- Bubble: stall=`6'b000011` for 1 cycle. Result: `id_instruction`=`NOP_WORD`, `id_valid`=0, `id_pc`=0, `state`=2, bubble counter=1. Release stall with `if_pc`=`32'h0000_000C`: captured next edge.
- Flush priority: `flush`=1 together with stall=`6'b000111`. Result: bubble loaded, `state`=3, flush counter +1, hold counter unchanged.
- Fetch-not-ready: `if_valid`=0, `if_instruction`=`32'hFFFF_FFFF`, stall=0. Result: `id_instruction`=`NOP_WORD`, `id_valid`=0, `state`=0.
- Saturation (PERF_EN): force the hold counter to `32'hFFFF_FFFE`, then hold for 3 cycles. Counter reads `32'hFFFF_FFFF` and stays there; reset returns it to 0.
